// File: rtl/if_id_fifo.sv
// IF/ID instruction buffer: circular FIFO between fetch and decode with jump flush and NOP fill.
// Optional zero-latency pass-through into an empty buffer when IF_ID_BYPASS_EN is defined.
module if_id_fifo #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000001,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             inst_i,
  input  logic [ADDR_W-1:0]       inst_addr_i,
  input  logic                    inst_valid_i,
  output logic                    inst_ready_o,
  input  logic                    hold_i,
  input  logic                    jump_flag_i,
  output logic [31:0]             inst_o,
  output logic [ADDR_W-1:0]       inst_addr_o,
  output logic                    inst_valid_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [15:0]             flush_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [31:0]       inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   flush_cnt_q, flush_cnt_d;
  logic [16:0]   flush_sum;

  logic not_empty;
  logic bypass;
  logic push;
  logic pop;

  assign not_empty    = (count_q != '0);
  assign inst_ready_o = (count_q < Full);

`ifdef IF_ID_BYPASS_EN
  assign bypass = ~not_empty & inst_valid_i & ~hold_i & ~jump_flag_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed straight from fetch and never touches storage.
  assign push = inst_valid_i & inst_ready_o & ~jump_flag_i & ~bypass;
  assign pop  = not_empty & ~hold_i & ~jump_flag_i;

  always_comb begin
    inst_valid_o = (not_empty | bypass) & ~jump_flag_i;
    inst_o       = NOP_INST;
    inst_addr_o  = '0;
    if (bypass) begin
      inst_o      = inst_i;
      inst_addr_o = inst_addr_i;
    end else if (inst_valid_o) begin
      inst_o      = inst_mem[rd_ptr_q];
      inst_addr_o = addr_mem[rd_ptr_q];
    end
  end

  assign flush_sum = {1'b0, flush_cnt_q} + 17'(count_q);

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    if (jump_flag_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Storage needs no reset; the valid state lives entirely in count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= inst_i;
      addr_mem[wr_ptr_q] <= inst_addr_i;
    end
  end

  assign count_o     = count_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo (DEPTH=2): vector table plus hand sequences for wrap,
// async reset and the fetch-to-decode latency / bypass path.
module tb_if_id_fifo;

  localparam logic [31:0] Nop = 32'h00000001;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic        hold_i;
  logic        jump_flag_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [1:0]  count_o;
  logic [15:0] flush_cnt_o;

  int total = 0;
  int bad   = 0;

  if_id_fifo #(
    .DEPTH    (2),
    .NOP_INST (32'h00000001),
    .ADDR_W   (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .hold_i       (hold_i),
    .jump_flag_i  (jump_flag_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .count_o      (count_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        hold;
    logic        jump;
    // outputs expected during the cycle, before the edge
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    logic [1:0]  e_count;
    logic [15:0] e_flush;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic h, input logic j);
    inst_valid_i = v;
    inst_i       = i;
    inst_addr_i  = a;
    hold_i       = h;
    jump_flag_i  = j;
  endtask

  initial begin
    // in: valid inst addr hold jump | exp: ready valid inst addr count flush
    vecs[0]  = '{1'b1, 32'h00A00093, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, Nop,          32'h0,  2'd0, 16'd0};
    vecs[1]  = '{1'b1, 32'h00108113, 32'h4,  1'b0, 1'b0, 1'b1, 1'b1, 32'h00A00093, 32'h0,  2'd1, 16'd0};
    vecs[2]  = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h00108113, 32'h4,  2'd1, 16'd0};
    vecs[3]  = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 1'b1, 1'b0, Nop,          32'h0,  2'd0, 16'd0};
    vecs[4]  = '{1'b1, 32'h11,       32'h8,  1'b1, 1'b0, 1'b1, 1'b0, Nop,          32'h0,  2'd0, 16'd0};
    vecs[5]  = '{1'b1, 32'h22,       32'hC,  1'b1, 1'b0, 1'b1, 1'b1, 32'h11,       32'h8,  2'd1, 16'd0};
    vecs[6]  = '{1'b1, 32'h33,       32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11,       32'h8,  2'd2, 16'd0};
    vecs[7]  = '{1'b1, 32'h33,       32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,       32'h8,  2'd2, 16'd0};
    vecs[8]  = '{1'b1, 32'h33,       32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22,       32'hC,  2'd1, 16'd0};
    vecs[9]  = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h33,       32'h10, 2'd1, 16'd0};
    vecs[10] = '{1'b1, 32'h44,       32'h14, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33,       32'h10, 2'd1, 16'd0};
    vecs[11] = '{1'b1, 32'h55,       32'h18, 1'b0, 1'b1, 1'b0, 1'b0, Nop,          32'h0,  2'd2, 16'd0};
    vecs[12] = '{1'b1, 32'h66,       32'h1C, 1'b0, 1'b1, 1'b1, 1'b0, Nop,          32'h0,  2'd0, 16'd2};
    vecs[13] = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 1'b1, 1'b0, Nop,          32'h0,  2'd0, 16'd2};

    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, Nop);
    check("rst_addr", inst_addr_o, 32'h0);
    check("rst_ready", 32'(inst_ready_o), 32'd1);
    check("rst_flush", 32'(flush_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].valid, vecs[k].inst, vecs[k].addr, vecs[k].hold, vecs[k].jump);
      #1;
      check($sformatf("v%0d_ready", k), 32'(inst_ready_o), 32'(vecs[k].e_ready));
      check($sformatf("v%0d_valid", k), 32'(inst_valid_o), 32'(vecs[k].e_valid));
      check($sformatf("v%0d_inst", k),  inst_o,            vecs[k].e_inst);
      check($sformatf("v%0d_addr", k),  inst_addr_o,       vecs[k].e_addr);
      check($sformatf("v%0d_count", k), 32'(count_o),      32'(vecs[k].e_count));
      check($sformatf("v%0d_flush", k), 32'(flush_cnt_o),  32'(vecs[k].e_flush));
    end

    // Streaming push+pop at count=1: addresses 0x0..0x24 in order across pointer wraps.
    @(negedge clk);
    drive(1'b1, 32'h1000, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h1000 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
      #1;
      check($sformatf("wrap%0d_count", i), 32'(count_o), 32'd1);
      check($sformatf("wrap%0d_addr", i), inst_addr_o, 32'(4 * (i - 1)));
      check($sformatf("wrap%0d_inst", i), inst_o, 32'h1000 + 32'(i - 1));
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("wrap_last_addr", inst_addr_o, 32'h24);
    check("wrap_last_inst", inst_o, 32'h1009);
    @(negedge clk);
    #1;
    check("wrap_drained", 32'(count_o), 32'd0);

    // Async reset mid-cycle with two entries buffered.
    drive(1'b1, 32'h77, 32'h40, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("pre_arst_count", 32'(count_o), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_valid", 32'(inst_valid_o), 32'd0);
    check("arst_inst", inst_o, Nop);
    check("arst_ready", 32'(inst_ready_o), 32'd1);
    check("arst_flush", 32'(flush_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Empty-buffer push: zero latency with bypass, one-cycle latency without.
    @(negedge clk);
    drive(1'b1, 32'h00000013, 32'h8, 1'b0, 1'b0);
    #1;
`ifdef IF_ID_BYPASS_EN
    check("byp_valid", 32'(inst_valid_o), 32'd1);
    check("byp_inst", inst_o, 32'h00000013);
    check("byp_addr", inst_addr_o, 32'h8);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("byp_count", 32'(count_o), 32'd0);
    check("byp_after_valid", 32'(inst_valid_o), 32'd0);
`else
    check("lat_valid0", 32'(inst_valid_o), 32'd0);
    check("lat_inst0", inst_o, Nop);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("lat_count", 32'(count_o), 32'd1);
    check("lat_inst1", inst_o, 32'h00000013);
    check("lat_addr1", inst_addr_o, 32'h8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
